axi4_bram_bridge: RTL and testbench

- AXI4 (full, burst-capable) slave that converts host transactions into the single-port BRAM-style access port of top_wrapped (addr_a/wrdata_a/rddata_a/en_a/we_a/rst_a).
- Sits directly upstream of top_wrapped; the host loads ifmap/filter buffers and reads back output buffers through this bridge.
- Serialises reads and writes onto the one port, handles bursts, backpressure and the 1-cycle BRAM read latency.

---
 rtl/axi4_bram_bridge.sv | 147 ++++++++++++++
 tb/tb_axi4_bram_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_bram_bridge.sv
// axi4_bram_bridge: AXI4 burst slave serialising reads and writes onto a single-port BRAM.
module axi4_bram_bridge #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_W-1:0]     s_awid,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic [1:0]          s_awburst,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_W-1:0]     s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_W-1:0]     s_arid,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic [1:0]          s_arburst,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_W-1:0]     s_rid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [ADDR_W-1:0]   addr_a,
    output logic [DATA_W-1:0]   wrdata_a,
    input  logic [DATA_W-1:0]   rddata_a,
    output logic                en_a,
    output logic [DATA_W/8-1:0] we_a,
    output logic                rst_a
);
    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_BURST} state_t;
    state_t state, state_nx;
    logic [ID_W-1:0] id;
    logic [ADDR_W-1:0] addr;
    logic [7:0] len, cnt;
    logic fixed, err, prio_rd, issued_all, infl, infl_last, wp, rp;
    logic [1:0] occ, pend;
    logic [1:0][DATA_W-1:0] fd;
    logic [1:0][1:0] fr;
    logic [1:0] fl;
    logic gw, gr, wr_beat, wr_end, rd_issue, pop;
    always_comb begin
        gw = s_awvalid && (!s_arvalid || !prio_rd);
        gr = s_arvalid && !gw;
        s_awready = state == IDLE && gw;
        s_arready = state == IDLE && gr;
        s_wready = state == WR_DATA;
        wr_beat = s_wready && s_wvalid;
        wr_end = wr_beat && (cnt == len || s_wlast);
        s_bvalid = state == WR_RESP;
        s_bid = s_bvalid ? id : '0;
        s_bresp = s_bvalid && err ? 2'b10 : 2'b00;
        s_rvalid = occ != 2'd0;
        pop = s_rvalid && s_rready;
        s_rid = s_rvalid ? id : '0;
        s_rdata = s_rvalid ? fd[rp] : '0;
        s_rresp = s_rvalid ? fr[rp] : 2'b00;
        s_rlast = s_rvalid && fl[rp];
        // issue only while the skid FIFO can absorb everything already in flight
        pend = occ + {1'b0, infl};
        rd_issue = state == RD_BURST && !issued_all && (pend < 2'd2 || (pop && pend == 2'd2));
        en_a = (wr_beat || rd_issue) && !err;
        we_a = en_a && wr_beat ? s_wstrb : '0;
        addr_a = en_a ? addr : '0;
        wrdata_a = en_a && wr_beat ? s_wdata : '0;
        rst_a = 1'b0;
        state_nx = (state == IDLE && gw) ? WR_DATA :
                   (state == IDLE && gr) ? RD_BURST :
                   wr_end ? WR_RESP :
                   (state == WR_RESP && s_bready) ? IDLE :
                   (state == RD_BURST && pop && s_rlast) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            id <= '0;
            addr <= '0;
            len <= '0;
            cnt <= '0;
            fixed <= 1'b0;
            err <= 1'b0;
            prio_rd <= 1'b0;
            issued_all <= 1'b0;
            infl <= 1'b0;
            infl_last <= 1'b0;
            wp <= 1'b0;
            rp <= 1'b0;
            occ <= '0;
            fd <= '0;
            fr <= '0;
            fl <= '0;
        end else begin
            state <= state_nx;
            if (s_awready) begin
                id <= s_awid;
                addr <= s_awaddr & ~ADDR_W'(3);
                len <= s_awlen;
                fixed <= s_awburst == 2'b00;
                err <= s_awburst[1] || s_awsize != 3'b010;
                cnt <= '0;
                prio_rd <= 1'b1;
            end
            if (s_arready) begin
                id <= s_arid;
                addr <= s_araddr & ~ADDR_W'(3);
                len <= s_arlen;
                fixed <= s_arburst == 2'b00;
                err <= s_arburst[1] || s_arsize != 3'b010;
                cnt <= '0;
                issued_all <= 1'b0;
                prio_rd <= 1'b0;
            end
            if (wr_beat) cnt <= cnt + 8'd1;
            // wlast disagreeing with the beat count poisons the response
            if (wr_beat && (s_wlast != (cnt == len))) err <= 1'b1;
            if ((wr_beat || rd_issue) && !fixed) addr <= addr + ADDR_W'(4);
            if (rd_issue) begin
                cnt <= cnt + 8'd1;
                issued_all <= cnt == len;
            end
            infl <= rd_issue;
            infl_last <= rd_issue && cnt == len;
            if (infl) begin
                fd[wp] <= err ? '0 : rddata_a;
                fr[wp] <= err ? 2'b10 : 2'b00;
                fl[wp] <= infl_last;
                wp <= ~wp;
            end
            if (pop) rp <= ~rp;
            occ <= occ + {1'b0, infl} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_axi4_bram_bridge.sv
// tb_axi4_bram_bridge: randomized bench comparing the bridge against a word-array memory model.
module tb_axi4_bram_bridge;
    localparam int AW = 22;
    localparam int IW = 4;
    logic clk = 0, rst_n = 0;
    logic [IW-1:0] s_awid = 0, s_arid = 0, s_bid, s_rid;
    logic [AW-1:0] s_awaddr = 0, s_araddr = 0, addr_a;
    logic [7:0] s_awlen = 0, s_arlen = 0;
    logic [2:0] s_awsize = 0, s_arsize = 0;
    logic [1:0] s_awburst = 0, s_arburst = 0, s_bresp, s_rresp;
    logic s_awvalid = 0, s_awready, s_arvalid = 0, s_arready;
    logic [31:0] s_wdata = 0, s_rdata, wrdata_a, rddata_a = 0;
    logic [3:0] s_wstrb = 0, we_a;
    logic s_wlast = 0, s_wvalid = 0, s_wready, s_bvalid, s_bready = 0;
    logic s_rlast, s_rvalid, s_rready = 0, en_a, rst_a;
    int errors = 0, checks = 0;
    logic [31:0] bram[int];
    logic [31:0] ref_mem[int];
    bit stall_en = 0, rnd_strb = 0;
    int out_cnt = 0, max_out = 0;

    axi4_bram_bridge #(.ADDR_W(AW), .DATA_W(32), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .addr_a(addr_a), .wrdata_a(wrdata_a), .rddata_a(rddata_a),
        .en_a(en_a), .we_a(we_a), .rst_a(rst_a)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] st);
        for (int b = 0; b < 4; b++) if (st[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    function automatic logic [31:0] ref_rd(logic [AW-1:0] a);
        return ref_mem.exists(int'(a >> 2)) ? ref_mem[int'(a >> 2)] : 32'h0;
    endfunction

    function automatic logic [AW-1:0] beat_addr(logic [AW-1:0] a, logic [1:0] burst, int i);
        return burst == 2'b00 ? a : a + AW'(4 * i);
    endfunction

    // BRAM with one-cycle read latency
    always @(posedge clk) begin
        if (en_a) begin
            if (we_a == 4'h0)
                rddata_a <= bram.exists(int'(addr_a >> 2)) ? bram[int'(addr_a >> 2)] : 32'h0;
            else
                bram[int'(addr_a >> 2)] = merge(bram.exists(int'(addr_a >> 2)) ? bram[int'(addr_a >> 2)] : 32'h0, wrdata_a, we_a);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) out_cnt = 0;
        else begin
            out_cnt = out_cnt + int'(en_a && we_a == 4'h0) - int'(s_rvalid && s_rready);
            if (out_cnt > max_out) max_out = out_cnt;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic aw_hs(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        s_awid = id; s_awaddr = a; s_awlen = len; s_awburst = burst; s_awsize = size; s_awvalid = 1;
        @(negedge clk);
        while (!s_awready && n < 50) begin @(negedge clk); n++; end
        if (!s_awready) chk("aw_timeout", 64'(s_awready), 64'(1));
        @(posedge clk); #1;
        s_awvalid = 0;
    endtask

    task automatic ar_hs(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        s_arid = id; s_araddr = a; s_arlen = len; s_arburst = burst; s_arsize = size; s_arvalid = 1;
        @(negedge clk);
        while (!s_arready && n < 50) begin @(negedge clk); n++; end
        if (!s_arready) chk("ar_timeout", 64'(s_arready), 64'(1));
        @(posedge clk); #1;
        s_arvalid = 0;
    endtask

    task automatic w_beat(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] st,
                          input bit last, input bit err);
        int n = 0;
        if (stall_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        s_wvalid = 1; s_wdata = d; s_wstrb = st; s_wlast = last;
        @(negedge clk);
        while (!s_wready && n < 50) begin @(negedge clk); n++; end
        chk("wr_port", {5'b0, en_a, we_a, addr_a, wrdata_a}, err ? 64'h0 : {5'b0, 1'b1, st, a, d});
        if (!err) ref_mem[int'(a >> 2)] = merge(ref_rd(a), d, st);
        @(posedge clk); #1;
        s_wvalid = 0; s_wlast = 0;
    endtask

    task automatic b_phase(input logic [IW-1:0] id, input logic [1:0] resp);
        int n = 0;
        s_bready = 0;
        @(negedge clk);
        while (!s_bvalid && n < 50) begin @(negedge clk); n++; end
        if (stall_en) repeat ($urandom_range(0, 2)) @(negedge clk);
        s_bready = 1;
        chk("bresp", 64'({s_bvalid, s_bid, s_bresp}), 64'({1'b1, id, resp}));
        @(posedge clk); #1;
        s_bready = 0;
    endtask

    task automatic wr_burst(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int lastpos,
                            input int nbeats, input logic [1:0] resp);
        bit err = burst[1] || size != 3'b010;
        aw_hs(id, a, len, burst, size);
        for (int i = 0; i < nbeats; i++)
            w_beat(beat_addr(a, burst, i), $urandom, rnd_strb ? 4'($urandom_range(1, 15)) : 4'hF, i == lastpos, err);
        b_phase(id, resp);
    endtask

    task automatic r_phase(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input bit err, input int mode);
        int got = 0, cyc = 0;
        bit stalled = 0;
        logic [31:0] held = 0;
        logic [3:0] pat = 4'b1001;
        while (got <= int'(len) && cyc < 2000) begin
            s_rready = mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stalled) chk("rd_hold", 64'({s_rvalid, s_rdata}), 64'({1'b1, held}));
            stalled = 0;
            if (s_rvalid) begin
                if (s_rready) begin
                    chk("rdata", 64'(s_rdata), 64'(err ? 32'h0 : ref_rd(beat_addr(a, burst, got))));
                    chk("rmeta", 64'({s_rid, s_rresp, s_rlast}), 64'({id, err ? 2'b10 : 2'b00, got == int'(len)}));
                    got++;
                end else begin
                    stalled = 1;
                    held = s_rdata;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_rready = 0;
        if (got <= int'(len)) chk("rd_timeout", 64'(got), 64'(int'(len) + 1));
    endtask

    task automatic rd_burst(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int mode);
        ar_hs(id, a, len, burst, size);
        r_phase(id, a, len, burst, burst[1] || size != 3'b010, mode);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_hs", 64'({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, en_a, we_a, s_bresp, s_rresp, rst_a}), 64'(0));
        chk("reset_port", {10'b0, addr_a, wrdata_a}, 64'(0));
        rst_n = 1;
        @(posedge clk); #1;
        // single write
        aw_hs(4'h3, 22'h000100, 8'd0, 2'b01, 3'b010);
        w_beat(22'h000100, 32'h0000_0037, 4'hF, 1, 0);
        b_phase(4'h3, 2'b00);
        chk("idle_after_write", 64'({en_a, we_a}), 64'(0));
        // long INCR write then read back
        wr_burst(4'h5, 22'h040000, 8'd24, 2'b01, 3'b010, 24, 25, 2'b00);
        rd_burst(4'h5, 22'h040000, 8'd24, 2'b01, 3'b010, 0);
        // stalled read, outstanding bounded by the skid FIFO
        max_out = 0;
        rd_burst(4'h6, 22'h040000, 8'd7, 2'b01, 3'b010, 1);
        chk("max_outstanding_le2", 64'(max_out <= 2), 64'(1));
        // simultaneous AW/AR: write first, then read
        s_awid = 4'h1; s_awaddr = 22'h000200; s_awlen = 0; s_awburst = 2'b01; s_awsize = 3'b010;
        s_arid = 4'h2; s_araddr = 22'h000200; s_arlen = 0; s_arburst = 2'b01; s_arsize = 3'b010;
        s_awvalid = 1; s_arvalid = 1;
        @(negedge clk);
        chk("arb_first", 64'({s_awready, s_arready}), 64'(2'b10));
        @(posedge clk); #1;
        s_awvalid = 0;
        w_beat(22'h000200, 32'hA5A5_0001, 4'hF, 1, 0);
        b_phase(4'h1, 2'b00);
        s_awid = 4'h4; s_awaddr = 22'h000204; s_awvalid = 1;
        @(negedge clk);
        chk("arb_second", 64'({s_awready, s_arready}), 64'(2'b01));
        @(posedge clk); #1;
        s_arvalid = 0;
        r_phase(4'h2, 22'h000200, 8'd0, 2'b01, 0, 0);
        aw_hs(4'h4, 22'h000204, 8'd0, 2'b01, 3'b010);
        w_beat(22'h000204, 32'h5A5A_0002, 4'hF, 1, 0);
        b_phase(4'h4, 2'b00);
        // error bursts
        wr_burst(4'h7, 22'h000300, 8'd3, 2'b01, 3'b010, 3, 4, 2'b00);
        wr_burst(4'h7, 22'h000300, 8'd3, 2'b10, 3'b010, 3, 4, 2'b10);
        rd_burst(4'h8, 22'h000300, 8'd3, 2'b01, 3'b010, 0);
        rd_burst(4'h8, 22'h000300, 8'd3, 2'b01, 3'b000, 0);
        wr_burst(4'h9, 22'h3F0000, 8'd3, 2'b01, 3'b010, 1, 2, 2'b10);
        wr_burst(4'h9, 22'h3F0100, 8'd1, 2'b01, 3'b010, 99, 2, 2'b10);
        // address wraps at 2^ADDR_W, and FIXED bursts
        wr_burst(4'hA, 22'h3FFFF8, 8'd3, 2'b01, 3'b010, 3, 4, 2'b00);
        rd_burst(4'hA, 22'h3FFFF8, 8'd3, 2'b01, 3'b010, 2);
        wr_burst(4'hB, 22'h000500, 8'd3, 2'b00, 3'b010, 3, 4, 2'b00);
        rd_burst(4'hB, 22'h000500, 8'd2, 2'b00, 3'b010, 2);
        // reset in the middle of a write burst
        aw_hs(4'hC, 22'h050000, 8'd15, 2'b01, 3'b010);
        for (int i = 0; i < 5; i++) w_beat(22'h050000 + 22'(4 * i), $urandom, 4'hF, 0, 0);
        s_wvalid = 1; s_wdata = $urandom; s_wstrb = 4'hF;
        #2 rst_n = 0;
        #1 chk("rst_mid", {5'b0, en_a, we_a, addr_a, wrdata_a}, 64'(0));
        chk("rst_mid_hs", 64'({s_wready, s_bvalid, s_rvalid}), 64'(0));
        s_wvalid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        chk("no_partial_b", 64'(s_bvalid), 64'(0));
        rd_burst(4'hD, 22'h050000, 8'd0, 2'b01, 3'b010, 0);
        rd_burst(4'hD, 22'h050000, 8'd5, 2'b01, 3'b010, 0);
        // randomized traffic
        stall_en = 1; rnd_strb = 1;
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] a = 22'h001000 + AW'(4 * $urandom_range(0, 63));
            logic [7:0] len = 8'($urandom_range(0, 15));
            logic [1:0] burst = 2'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) wr_burst(4'($urandom), a, len, burst, 3'b010, int'(len), int'(len) + 1, 2'b00);
            else rd_burst(4'($urandom), a, len, burst, 3'b010, 2);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
